// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle wide adder. Two DATA_W-bit operands are added one nibble per
// clock, least-significant nibble first, through a single combinational 4-bit
// carry-lookahead slice. The running carry is held in a register between
// nibbles, so no carry chain ever spans more than one nibble in a cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_in_valid   operands valid (sampled only while o_in_ready is high)
//   o_in_ready   block is idle and can accept operands
//   i_in_a       operand A
//   i_in_b       operand B
//   i_in_cin     carry-in for nibble 0
//   o_out_valid  result valid (held until i_out_ready)
//   i_out_ready  downstream accepts the result (ignored outside DONE)
//   o_out_sum    {carry_out, sum}, DATA_W+1 bits, holds last result
//   o_out_ovf    two's-complement overflow of the last result
//
// Timing: operands accepted at edge E0, nibble k processed at edge E(k+1),
// o_out_valid high from just after E(NUM_NIB). Minimum issue interval is
// NUM_NIB+2 cycles.
//
// NUM_NIB must lie in 2..8; DATA_W is derived from it and must not be
// overridden on its own.
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int NUM_NIB = 4,
    parameter int DATA_W  = 4 * NUM_NIB
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_a,
    input  logic [DATA_W-1:0] i_in_b,
    input  logic              i_in_cin,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W:0]   o_out_sum,
    output logic              o_out_ovf
);

    localparam int               CNT_W    = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Working registers. The operands are shifted right one nibble per RUN
    // cycle so the slice always reads bits [3:0]; the partial sum is shifted
    // in from the top, so after NUM_NIB cycles nibble k sits at position k.
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_sum;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;

    // Result registers, separate from the working registers so the previous
    // result stays visible through IDLE and RUN.
    logic [DATA_W:0]   r_out_sum;
    logic              r_out_ovf;

    // ---------------------------------------------------------------------
    // 4-bit carry-lookahead slice
    // ---------------------------------------------------------------------
    logic [3:0] w_nib_a;
    logic [3:0] w_nib_b;
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_nib_sum;
    logic       w_cin;
    logic [4:0] w_c;        // w_c[i] = carry into bit i, w_c[4] = carry out

    assign w_nib_a = r_a[3:0];
    assign w_nib_b = r_b[3:0];
    assign w_cin   = r_carry;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice_bit
            assign w_g[gi]       = w_nib_a[gi] & w_nib_b[gi];
            assign w_p[gi]       = w_nib_a[gi] ^ w_nib_b[gi];
            assign w_nib_sum[gi] = w_p[gi] ^ w_c[gi];
        end
    endgenerate

    // Every carry is a flat sum of products of g/p and the slice carry-in;
    // none is built from a lower carry, so the slice has no ripple path.
    assign w_c[0] = w_cin;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & w_cin);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & w_cin);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_cin);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cin);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (i_in_valid)          w_state_next = S_RUN;
            S_RUN:  if (r_cnt == LAST_CNT)   w_state_next = S_DONE;
            S_DONE: if (i_out_ready)         w_state_next = S_IDLE;
            default:                         w_state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  o_in_ready  = 1'b1;
            S_DONE:  o_out_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_out_sum = r_out_sum;
    assign o_out_ovf = r_out_ovf;

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_out_sum <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // o_in_ready is high throughout IDLE, so i_in_valid alone
                    // completes the input handshake here.
                    if (i_in_valid) begin
                        r_a     <= i_in_a;
                        r_b     <= i_in_b;
                        r_carry <= i_in_cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_c[4];
                    r_sum   <= {w_nib_sum, r_sum[DATA_W-1:4]};
                    r_cnt   <= r_cnt + 1'b1;
                    // Top nibble: publish the finished result. Overflow is
                    // the carry into the MSB XOR the carry out of the MSB.
                    if (r_cnt == LAST_CNT) begin
                        r_out_sum <= {w_c[4], w_nib_sum, r_sum[DATA_W-1:4]};
                        r_out_ovf <= w_c[3] ^ w_c[4];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int NN  = 4;
    localparam int W   = 4 * NN;
    localparam int NN2 = 2;
    localparam int W2  = 4 * NN2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Default instance (NUM_NIB = 4)
    logic          in_valid  = 1'b0;
    logic          in_cin    = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_a      = '0;
    logic [W-1:0]  in_b      = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ovf;
    logic [W:0]    out_sum;

    // Narrow instance (NUM_NIB = 2)
    logic          s2_in_valid  = 1'b0;
    logic          s2_in_cin    = 1'b0;
    logic          s2_out_ready = 1'b0;
    logic [W2-1:0] s2_in_a      = '0;
    logic [W2-1:0] s2_in_b      = '0;
    logic          s2_in_ready;
    logic          s2_out_valid;
    logic          s2_out_ovf;
    logic [W2:0]   s2_out_sum;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NUM_NIB(NN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .i_in_cin    (in_cin),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_sum   (out_sum),
        .o_out_ovf   (out_ovf)
    );

    nibble_serial_adder #(.NUM_NIB(NN2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (s2_in_valid),
        .o_in_ready  (s2_in_ready),
        .i_in_a      (s2_in_a),
        .i_in_b      (s2_in_b),
        .i_in_cin    (s2_in_cin),
        .o_out_valid (s2_out_valid),
        .i_out_ready (s2_out_ready),
        .o_out_sum   (s2_out_sum),
        .o_out_ovf   (s2_out_ovf)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on w-bit operands.
    function automatic longint ref_sum(input int w, input longint a, input longint b, input int c);
        longint s;
        s = a + b + longint'(c);
        return s & ((longint'(1) << (w + 1)) - 1);
    endfunction

    function automatic logic ref_ovf(input int w, input longint a, input longint b, input int c);
        longint sa;
        longint sb;
        longint s;
        longint lim;
        lim = longint'(1) << (w - 1);
        sa  = (a >= lim) ? a - (longint'(1) << w) : a;
        sb  = (b >= lim) ? b - (longint'(1) << w) : b;
        s   = sa + sb + longint'(c);
        return (s >= lim) || (s < -lim);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the NUM_NIB=4 instance. 'hold' = number of DONE
    // cycles with out_ready low; during them in_valid is driven high with
    // junk operands that must not be taken.
    task automatic txn4(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int hold, input string tag);
        longint exp_s;
        logic   exp_o;
        int     guard;
        int     low;
        exp_s = ref_sum(W, longint'(a), longint'(b), int'(c));
        exp_o = ref_ovf(W, longint'(a), longint'(b), int'(c));
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, ".idle_ready"}, 64'(in_ready), 64'(1));
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = c;
        out_ready = (hold == 0);
        tick();                                  // E0
        in_valid = (hold > 0);
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
        low = 0;
        for (int k = 0; k < NN; k++) begin
            chk({tag, ".run_valid"}, 64'(out_valid), 64'(0));
            if (in_ready === 1'b0) low++;
            tick();
        end
        for (int d = 0; d <= hold; d++) begin
            out_ready = (d == hold);
            chk({tag, ".done_valid"}, 64'(out_valid), 64'(1));
            chk({tag, ".sum"}, 64'(out_sum), 64'(exp_s));
            chk({tag, ".ovf"}, 64'(out_ovf), 64'(exp_o));
            if (in_ready === 1'b0) low++;
            tick();
        end
        in_valid = 1'b0;
        chk({tag, ".idle_valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".idle_ready2"}, 64'(in_ready), 64'(1));
        chk({tag, ".held_sum"}, 64'(out_sum), 64'(exp_s));
        chk({tag, ".busy_cycles"}, 64'(low), 64'(NN + 1 + hold));
        $display("txn %s: a=0x%0h b=0x%0h cin=%0d hold=%0d -> sum=0x%0h ovf=%0d",
                 tag, a, b, c, hold, out_sum, out_ovf);
    endtask

    task automatic txn2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c,
                        input string tag);
        longint exp_s;
        logic   exp_o;
        int     guard;
        exp_s = ref_sum(W2, longint'(a), longint'(b), int'(c));
        exp_o = ref_ovf(W2, longint'(a), longint'(b), int'(c));
        guard = 0;
        while (s2_in_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, ".idle_ready"}, 64'(s2_in_ready), 64'(1));
        s2_in_valid  = 1'b1;
        s2_in_a      = a;
        s2_in_b      = b;
        s2_in_cin    = c;
        s2_out_ready = 1'b1;
        tick();                                  // E0
        s2_in_valid = 1'b0;
        for (int k = 0; k < NN2; k++) begin
            chk({tag, ".run_valid"}, 64'(s2_out_valid), 64'(0));
            tick();
        end
        chk({tag, ".done_valid"}, 64'(s2_out_valid), 64'(1));
        chk({tag, ".sum"}, 64'(s2_out_sum), 64'(exp_s));
        chk({tag, ".ovf"}, 64'(s2_out_ovf), 64'(exp_o));
        tick();
        chk({tag, ".idle_valid"}, 64'(s2_out_valid), 64'(0));
        $display("txn %s: a=0x%0h b=0x%0h cin=%0d -> sum=0x%0h ovf=%0d",
                 tag, a, b, c, s2_out_sum, s2_out_ovf);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready",  64'(in_ready),  64'(1));
        chk("rst.out_valid", 64'(out_valid), 64'(0));
        chk("rst.out_sum",   64'(out_sum),   64'(0));
        chk("rst.out_ovf",   64'(out_ovf),   64'(0));
        chk("rst.n2_sum",    64'(s2_out_sum), 64'(0));
        rst_n = 1'b1;
        tick();

        // Basic add
        txn4(16'h1234, 16'h4321, 1'b0, 0, "basic");
        chk("basic.const_sum", 64'(out_sum), 64'h05555);
        chk("basic.const_ovf", 64'(out_ovf), 64'(0));

        // Reset in the middle of RUN, after two nibbles
        in_valid  = 1'b1;
        in_a      = 16'h1234;
        in_b      = 16'h4321;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst.in_ready",  64'(in_ready),  64'(1));
        chk("midrst.out_valid", 64'(out_valid), 64'(0));
        chk("midrst.out_sum",   64'(out_sum),   64'(0));
        chk("midrst.out_ovf",   64'(out_ovf),   64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst.hold_valid", 64'(out_valid), 64'(0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst.post_valid", 64'(out_valid), 64'(0));
            chk("midrst.post_ready", 64'(in_ready),  64'(1));
        end
        $display("txn midrst: reset during RUN, result discarded");

        // Carry chain and signed overflow
        txn4(16'hFFFF, 16'h0001, 1'b0, 0, "carry1");
        chk("carry1.const_sum", 64'(out_sum), 64'h10000);
        chk("carry1.const_ovf", 64'(out_ovf), 64'(0));
        txn4(16'hFFFF, 16'hFFFF, 1'b1, 0, "carry2");
        chk("carry2.const_sum", 64'(out_sum), 64'h1FFFF);
        txn4(16'h7FFF, 16'h0001, 1'b0, 0, "ovf1");
        chk("ovf1.const_sum", 64'(out_sum), 64'h08000);
        chk("ovf1.const_ovf", 64'(out_ovf), 64'(1));
        txn4(16'h8000, 16'h8000, 1'b0, 0, "ovf2");
        chk("ovf2.const_sum", 64'(out_sum), 64'h10000);
        chk("ovf2.const_ovf", 64'(out_ovf), 64'(1));

        // Backpressure: 3 cycles with out_ready low and in_valid pushing junk
        txn4(16'h1234, 16'h4321, 1'b0, 3, "bp");
        chk("bp.const_sum", 64'(out_sum), 64'h05555);

        // Narrow instance
        txn2(8'hFF, 8'h01, 1'b1, "n2");
        chk("n2.const_sum", 64'(s2_out_sum), 64'h101);
        for (int i = 0; i < 30; i++) begin
            txn2(W2'($urandom), W2'($urandom), 1'($urandom), "n2rnd");
        end

        // Random operands on the default instance
        for (int i = 0; i < 500; i++) begin
            txn4(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
